// File: rtl/reset_seq_pkg.sv
// Shared types for the board reset sequencer: FSM state encoding and reset-cause codes.
// Contents: state_t {HOLD, RELEASE, RUN}, CAUSE_* codes, pick_cause() priority helper.
// Used by: reset_sequencer (top). Optional feature macro: RESET_SEQ_WATCHDOG_EN (see top).
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    // Winner among simultaneous requests: button > watchdog > software.
    // Only called when at least one request is active.
    function automatic logic [1:0] pick_cause(input logic btn, input logic wdt);
        if (btn)
            return CAUSE_BTN;
        else if (wdt)
            return CAUSE_WDT;
        else
            return CAUSE_SW;
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// Push-button conditioning: 2-FF synchronizer followed by a saturating debounce counter.
// Ports: CLK_48MHZ/RESET (async, active high), EXT_RESET_N_IN (raw, active low) -> btn_req.
// btn_req is high while the synchronized level has been low for DEBOUNCE_CYCLES samples (2+N latency).
module reset_debounce #(
    parameter int DEBOUNCE_CYCLES = 48000
) (
    input  logic CLK_48MHZ,
    input  logic RESET,
    input  logic EXT_RESET_N_IN,
    output logic btn_req
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;

    // Synchronizer resets to the released (high) level so reset never looks like a press.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], EXT_RESET_N_IN};
            if (r_sync[1])
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign btn_req = (r_cnt == CNT_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: debounced button, software and optional watchdog requests stretch a
// hold period, then NUM_STAGES resets release in order (bit 0 first), STAGE_GAP cycles apart.
// Ports: CLK_48MHZ, RESET (async high), EXT_RESET_N_IN, SW_RESET_REQ, WDT_KICK -> RST_OUT, SYS_READY,
// RESET_CAUSE. Macro RESET_SEQ_WATCHDOG_EN builds the watchdog; otherwise WDT_KICK is ignored.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int HOLD_CYCLES     = 480,
    parameter int STAGE_GAP       = 48,
    parameter int NUM_STAGES      = 3,
    parameter int WDT_CYCLES      = 48000000
) (
    input  logic                  CLK_48MHZ,
    input  logic                  RESET,
    input  logic                  EXT_RESET_N_IN,
    input  logic                  SW_RESET_REQ,
    input  logic                  WDT_KICK,
    output logic [NUM_STAGES-1:0] RST_OUT,
    output logic                  SYS_READY,
    output logic [1:0]            RESET_CAUSE
);

    localparam int                HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    // RUN is entered one cycle after the last stage releases at (NUM_STAGES-1)*STAGE_GAP.
    localparam int                REL_LAST_I = (NUM_STAGES - 1) * STAGE_GAP + 1;
    localparam int                REL_W      = $clog2(REL_LAST_I + 1);
    localparam logic [REL_W-1:0]  REL_LAST   = REL_W'(REL_LAST_I);

    state_t                  r_state, w_state_nxt;
    logic [HOLD_W-1:0]       r_hold_cnt, w_hold_nxt;
    logic [REL_W-1:0]        r_rel_cnt, w_rel_nxt;
    logic [1:0]              r_cause, w_cause_nxt;
    logic [NUM_STAGES-1:0]   r_rst_out, w_rst_nxt;
    logic                    r_sys_ready, w_ready_nxt;
    logic                    w_btn_req;
    logic                    w_wdt_req;
    logic                    w_req_any;

    reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK_48MHZ      (CLK_48MHZ),
        .RESET          (RESET),
        .EXT_RESET_N_IN (EXT_RESET_N_IN),
        .btn_req        (w_btn_req)
    );

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int               WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt_cnt;

    // Counts only while staying in RUN; any exit from RUN or a kick restarts it.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET)
            r_wdt_cnt <= '0;
        else if (r_state != RUN || w_state_nxt != RUN || WDT_KICK)
            r_wdt_cnt <= '0;
        else if (r_wdt_cnt != WDT_LAST)
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end

    assign w_wdt_req = (r_state == RUN) && (r_wdt_cnt == WDT_LAST);
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic w_unused_kick;
    assign w_unused_kick = WDT_KICK;
    assign w_wdt_req     = 1'b0;
`endif

    // Software requests are only meaningful outside HOLD; the HOLD branch never looks at this.
    assign w_req_any = w_btn_req | w_wdt_req | SW_RESET_REQ;

    // State and registered outputs.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            r_state     <= HOLD;
            r_hold_cnt  <= '0;
            r_rel_cnt   <= '0;
            r_cause     <= CAUSE_POR;
            r_rst_out   <= '1;
            r_sys_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_rel_cnt   <= w_rel_nxt;
            r_cause     <= w_cause_nxt;
            r_rst_out   <= w_rst_nxt;
            r_sys_ready <= w_ready_nxt;
        end
    end

    // Next-state, counters and cause.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_rel_nxt   = r_rel_cnt;
        w_cause_nxt = r_cause;
        unique case (r_state)
            HOLD: begin
                // A held button keeps restarting the hold without touching the cause.
                if (w_btn_req)
                    w_hold_nxt = '0;
                else if (r_hold_cnt >= HOLD_LAST) begin
                    w_state_nxt = RELEASE;
                    w_rel_nxt   = '0;
                end else
                    w_hold_nxt = r_hold_cnt + 1'b1;
            end
            RELEASE, RUN: begin
                if (w_req_any) begin
                    w_state_nxt = HOLD;
                    w_hold_nxt  = '0;
                    w_cause_nxt = pick_cause(w_btn_req, w_wdt_req);
                end else if (r_state == RELEASE) begin
                    if (r_rel_cnt >= REL_LAST)
                        w_state_nxt = RUN;
                    else
                        w_rel_nxt = r_rel_cnt + 1'b1;
                end
            end
            default: w_state_nxt = HOLD;
        endcase
    end

    // Output values for the next cycle, derived from the upcoming state.
    always_comb begin
        w_rst_nxt   = r_rst_out;
        w_ready_nxt = 1'b0;
        unique case (w_state_nxt)
            HOLD: w_rst_nxt = '1;
            RELEASE: begin
                // Stage k drops on the edge where rel_cnt reaches k*STAGE_GAP and stays low.
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (r_state == RELEASE && int'(r_rel_cnt) == k * STAGE_GAP)
                        w_rst_nxt[k] = 1'b0;
                end
            end
            RUN: begin
                w_rst_nxt   = '0;
                w_ready_nxt = 1'b1;
            end
            default: w_rst_nxt = '1;
        endcase
    end

    assign RST_OUT     = r_rst_out;
    assign SYS_READY   = r_sys_ready;
    assign RESET_CAUSE = r_cause;

endmodule
